// File: rtl/vga_bus_pkg.sv
// Shared definitions for the VGA host-bus front end: register map, status
// byte layout, read FSM states and the write FIFO entry format.
package vga_bus_pkg;

    // Host register addresses
    localparam logic [3:0] REG_STATUS = 4'd0;
    localparam logic [3:0] REG_CTRL   = 4'd2;
    localparam logic [3:0] REG_DATA   = 4'd3;

    // Status byte bit positions
    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_BUSY     = 3;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRAIN,
        R_REQ,
        R_WAIT
    } rd_state_e;

    // One queued host write
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    // Assemble the locally served status byte; upper nibble reads as zero
    function automatic logic [7:0] make_status(input logic empty, input logic full,
                                               input logic ovf, input logic busy);
        logic [7:0] s;
        s              = 8'h00;
        s[ST_EMPTY]    = empty;
        s[ST_FULL]     = full;
        s[ST_OVERFLOW] = ovf;
        s[ST_BUSY]     = busy;
        return s;
    endfunction

endpackage

// File: rtl/vga_bus_if_if.sv
// Core-side bundle of the VGA host-bus front end: write FIFO drain
// (valid/ready) and the read request/acknowledge pair.
// master = front end (vga_bus_if), slave = VGA core.
interface vga_bus_if_if;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_ack;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ready, rd_data, rd_ack
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ready, rd_data, rd_ack
    );
endinterface

// File: rtl/vga_bus_if_bus_wr_fifo.sv
// Show-ahead synchronous FIFO for buffered host writes. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module bus_wr_fifo
    import vga_bus_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wr_entry_t push_data_i,
    input  logic      pop_i,
    output wr_entry_t head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);

    wr_entry_t       mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            do_push, do_pop;

    // Flag decode and push/pop qualification
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
    end

    // Storage array
    // NOTE: the data array is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    // Read/write pointers with wrap bit
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking <= so all flops update from pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vga_bus_if.sv
// VGA host-bus front end: synchronises ncs/nwr/nrd, turns strobes into
// single-cycle events, queues writes toward the core, serves status reads
// locally and forwards other reads once all earlier writes have drained.
// Optional: define BUS_IF_GLITCH_FILTER_EN to require two consecutive active
// synchronised samples before a strobe event fires (+1 clk latency).
module vga_bus_if
    import vga_bus_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ncs,
    input  logic         nwr,
    input  logic         nrd,
    input  logic [3:0]   ext_address,
    input  logic [7:0]   db_in,
    output logic [7:0]   db_out,
    output logic         db_oe,
    vga_bus_if_if.master core
);

    logic [SYNC_STAGES-1:0] ncs_sync_q, nwr_sync_q, nrd_sync_q;
    logic                   wr_act, rd_act, wr_act_q, rd_act_q;
    logic                   wr_rise, rd_rise, wr_ev, rd_ev;
`ifdef BUS_IF_GLITCH_FILTER_EN
    logic                   wr_act_q2, rd_act_q2;
`endif
    logic                   push_req, pop, drop, ovf_clr;
    logic                   overflow_q, overflow_d;
    logic                   fifo_empty, fifo_full;
    wr_entry_t              fifo_head;
    logic [7:0]             status;
    rd_state_e              state_q;
    logic                   rd_req_q;
    logic [3:0]             rd_addr_q;
    logic [7:0]             db_out_q;

    // Multi-flop synchronisers, reset to the inactive (high) level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync_q <= '1;
            nwr_sync_q <= '1;
            nrd_sync_q <= '1;
        end else begin
            ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            nwr_sync_q <= {nwr_sync_q[SYNC_STAGES-2:0], nwr};
            nrd_sync_q <= {nrd_sync_q[SYNC_STAGES-2:0], nrd};
        end
    end

    // History of the active levels for edge (and glitch) detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_act_q  <= 1'b0;
            rd_act_q  <= 1'b0;
`ifdef BUS_IF_GLITCH_FILTER_EN
            wr_act_q2 <= 1'b0;
            rd_act_q2 <= 1'b0;
`endif
        end else begin
            wr_act_q  <= wr_act;
            rd_act_q  <= rd_act;
`ifdef BUS_IF_GLITCH_FILTER_EN
            wr_act_q2 <= wr_act_q;
            rd_act_q2 <= rd_act_q;
`endif
        end
    end

    // Strobe events and write-path control
    always_comb begin
        wr_act = ~ncs_sync_q[SYNC_STAGES-1] & ~nwr_sync_q[SYNC_STAGES-1];
        rd_act = ~ncs_sync_q[SYNC_STAGES-1] & ~nrd_sync_q[SYNC_STAGES-1];
`ifdef BUS_IF_GLITCH_FILTER_EN
        wr_rise = wr_act & wr_act_q & ~wr_act_q2;
        rd_rise = rd_act & rd_act_q & ~rd_act_q2;
`else
        wr_rise = wr_act & ~wr_act_q;
        rd_rise = rd_act & ~rd_act_q;
`endif
        // Simultaneous write and read strobes count as a write only
        wr_ev    = wr_rise;
        rd_ev    = rd_rise & ~wr_act;
        pop      = ~fifo_empty & core.wr_ready;
        push_req = wr_ev & (ext_address != REG_STATUS);
        ovf_clr  = wr_ev & (ext_address == REG_STATUS);
        drop     = push_req & fifo_full & ~pop;
        overflow_d = overflow_q;
        if (ovf_clr)   overflow_d = 1'b0;
        else if (drop) overflow_d = 1'b1;
        status = make_status(fifo_empty, fifo_full, overflow_q, state_q != R_IDLE);
    end

    // Sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    bus_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_req),
        .push_data_i ('{addr: ext_address, data: db_in}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Read FSM: status locally, other reads wait for the FIFO to drain first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= R_IDLE;
            rd_req_q  <= 1'b0;
            rd_addr_q <= 4'd0;
            db_out_q  <= 8'h00;
        end else begin
            rd_req_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (rd_ev) begin
                        if (ext_address == REG_STATUS) begin
                            db_out_q <= status;
                        end else begin
                            rd_addr_q <= ext_address;
                            state_q   <= R_DRAIN;
                        end
                    end
                end
                // An empty FIFO implies no pop can be in flight
                R_DRAIN: begin
                    if (fifo_empty) begin
                        state_q  <= R_REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                R_REQ: state_q <= R_WAIT;
                R_WAIT: begin
                    if (core.rd_ack) begin
                        db_out_q <= core.rd_data;
                        state_q  <= R_IDLE;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign core.wr_valid = ~fifo_empty;
    assign core.wr_addr  = fifo_head.addr;
    assign core.wr_data  = fifo_head.data;
    assign core.rd_req   = rd_req_q;
    assign core.rd_addr  = rd_addr_q;
    assign db_out        = db_out_q;
    assign db_oe         = rd_act;

endmodule
